// File: rtl/cdr_strobe_gen_if.sv
// Timing-loop <-> strobe generator bus.
//   i_en    run enable
//   i_nb_P  samples per symbol period
//   i_sync  phase restart pulse
//   i_adv   shorten-next-period nudge
//   i_ret   lengthen-next-period nudge
//   o_mid   decision strobe
//   o_end   period-boundary strobe
//   o_phase phase counter
//   o_adj   applied adjustment (01 adv, 10 ret)
// master: TED/loop side (drives i_*); slave: strobe generator.
interface cdr_strobe_gen_if #(
  parameter int CNT_W = 6
);
  logic             i_en;
  logic [CNT_W-1:0] i_nb_P;
  logic             i_sync;
  logic             i_adv;
  logic             i_ret;
  logic             o_mid;
  logic             o_end;
  logic [CNT_W-1:0] o_phase;
  logic [1:0]       o_adj;

  modport master (
    output i_en, i_nb_P, i_sync, i_adv, i_ret,
    input  o_mid, o_end, o_phase, o_adj
  );

  modport slave (
    input  i_en, i_nb_P, i_sync, i_adv, i_ret,
    output o_mid, o_end, o_phase, o_adj
  );
endinterface

// File: rtl/cdr_strobe_gen.sv
// Symbol-timing strobe generator for the CDR.
// Counts oversampled clocks per symbol period, emits a mid-period decision
// strobe and an end-of-period strobe, applies at most one +/-1 sample nudge
// per period and supports a phase-restart sync.
// Ports:
//   i_clk  clock
//   i_rst  synchronous reset, active-high
//   bus    cdr_strobe_gen_if.slave (enable, period, sync, nudges, strobes)
module cdr_strobe_gen #(
  parameter int CNT_W = 6,
  parameter int P_MIN = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  cdr_strobe_gen_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  // Pending-nudge codes double as the o_adj encoding.
  localparam logic [1:0] PEND_NONE = 2'b00;
  localparam logic [1:0] PEND_ADV  = 2'b01;
  localparam logic [1:0] PEND_RET  = 2'b10;

  localparam logic [CNT_W-1:0] PMIN_V = CNT_W'(P_MIN);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] p_lat;
  logic [1:0]       pend;
  logic             hold;
  logic [1:0]       adj_q;

  logic [CNT_W-1:0] p_in;
  logic [CNT_W-1:0] p_last;
  logic [CNT_W-1:0] mid_pt;
  logic             wrap;

  // Adv and ret cancel each other; a single nudge either cancels an opposite
  // pending nudge or saturates in its own direction.
  function automatic logic [1:0] nudge(input logic [1:0] p, input logic adv,
                                       input logic ret);
    logic [1:0] r;
    r = p;
    if (adv && !ret)      r = (p == PEND_RET) ? PEND_NONE : PEND_ADV;
    else if (ret && !adv) r = (p == PEND_ADV) ? PEND_NONE : PEND_RET;
    return r;
  endfunction

  assign p_in   = (bus.i_nb_P < PMIN_V) ? PMIN_V : bus.i_nb_P;
  assign p_last = p_lat - CNT_W'(1);
  assign mid_pt = p_last >> 1;
  assign wrap   = (cnt == p_last);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.i_en)  state_nxt = S_RUN;
      S_RUN:   if (!bus.i_en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Phase counter, period latch and nudge bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt   <= '0;
      p_lat <= PMIN_V;
      pend  <= PEND_NONE;
      hold  <= 1'b0;
      adj_q <= PEND_NONE;
    end else begin
      adj_q <= PEND_NONE;
      if (state == S_IDLE) begin
        cnt  <= '0;
        pend <= PEND_NONE;
        hold <= 1'b0;
        if (bus.i_en) p_lat <= p_in;
      end else if (!bus.i_en) begin
        cnt  <= '0;
        pend <= PEND_NONE;
        hold <= 1'b0;
      end else if (bus.i_sync) begin
        // Sync beats a coincident wrap: pending nudge is dropped, no o_adj.
        cnt   <= '0;
        p_lat <= p_in;
        pend  <= PEND_NONE;
        hold  <= 1'b0;
      end else if (hold) begin
        // Extra cycle at phase 0 realising a retard.
        hold <= 1'b0;
        pend <= nudge(pend, bus.i_adv, bus.i_ret);
      end else if (wrap) begin
        p_lat <= p_in;
        adj_q <= pend;
        cnt   <= (pend == PEND_ADV) ? CNT_W'(1) : '0;
        hold  <= (pend == PEND_RET);
        // Nudge arriving in the wrap cycle belongs to the following period.
        pend  <= nudge(PEND_NONE, bus.i_adv, bus.i_ret);
      end else begin
        cnt  <= cnt + CNT_W'(1);
        pend <= nudge(pend, bus.i_adv, bus.i_ret);
      end
    end
  end

  // Outputs: register decode only
  always_comb begin
    bus.o_mid   = 1'b0;
    bus.o_end   = 1'b0;
    bus.o_phase = '0;
    bus.o_adj   = adj_q;
    if (state == S_RUN) begin
      bus.o_mid   = (cnt == mid_pt) && !hold;
      bus.o_end   = wrap;
      bus.o_phase = cnt;
    end
  end

endmodule
